signed_seq_divider: RTL and testbench

Sequential signed integer divider, the inverse companion of the combinational signed Booth array multiplier in the lab datapath. It accepts an N-bit two's-complement dividend and divisor through a start/ready handshake and produces the quotient and remainder in one quotient bit per cycle using unsigned restoring division on magnitudes. A final sign-fixup cycle applies C-style truncation toward zero. Results are held stable for the consuming datapath until the next accepted operation.

---
 rtl/signed_div_pkg.sv | 16 +
 rtl/signed_seq_divider_div_step.sv | 23 ++
 rtl/signed_seq_divider.sv | 141 ++++++++++++++
 tb/tb_signed_seq_divider.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package signed_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter holds N-1 down to 0; at least one bit even for tiny N.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit,
// try to subtract the divisor, keep the difference when it does not borrow.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   rem,
    input  logic         dd_bit,
    input  logic [N-1:0] divisor_mag,
    output logic [N:0]   rem_next,
    output logic         q_bit
);

    logic [N+1:0] trial;

    // rem[N] is always zero between steps, so bit N+1 of the trial is a
    // reliable borrow/sign indicator.
    always_comb begin
        trial    = {rem, dd_bit} - {2'b00, divisor_mag};
        q_bit    = ~trial[N+1];
        rem_next = q_bit ? trial[N:0] : {rem[N-1:0], dd_bit};
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider: magnitude restoring division, one quotient bit
// per cycle, then a sign fix-up. Optional macro SIGNED_DIV_ZERO_EN adds o_div_zero.
module signed_seq_divider
    import signed_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_ready,
    output logic         o_done,
    output logic [N-1:0] o_q,
    output logic [N-1:0] o_r
`ifdef SIGNED_DIV_ZERO_EN
    ,
    output logic         o_div_zero
`endif
);

    localparam int CW = cnt_width(N);

    state_t state, state_next;

    logic [N-1:0]  dd_sr;          // dividend magnitude, becomes quotient magnitude
    logic [N-1:0]  dv_mag;
    logic [N-1:0]  dividend_raw;
    logic [N:0]    rem;
    logic          q_neg;
    logic          r_neg;
    logic          dv_zero;
    logic [CW-1:0] cnt;

    logic [N:0]    rem_step;
    logic          q_bit;
    logic [N-1:0]  dd_mag_in;
    logic [N-1:0]  dv_mag_in;
    logic          zero_in;
    logic [N-1:0]  q_fix;
    logic [N-1:0]  r_fix;

    // Magnitude of the most negative value wraps to 2^(N-1), which is
    // exactly right as an unsigned N-bit number.
    assign dd_mag_in = i_dividend[N-1] ? -i_dividend : i_dividend;
    assign dv_mag_in = i_divisor[N-1]  ? -i_divisor  : i_divisor;
    assign zero_in   = (i_divisor == '0);
    assign o_ready   = (state == IDLE);

    div_step #(.N(N)) u_step (
        .rem         (rem),
        .dd_bit      (dd_sr[N-1]),
        .divisor_mag (dv_mag),
        .rem_next    (rem_step),
        .q_bit       (q_bit)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
`ifdef SIGNED_DIV_ZERO_EN
                    state_next = zero_in ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divide-by-zero results are forced here regardless of what CALC left.
    always_comb begin
        q_fix = q_neg ? -dd_sr : dd_sr;
        r_fix = r_neg ? -rem[N-1:0] : rem[N-1:0];
        if (dv_zero) begin
            q_fix = '1;
            r_fix = dividend_raw;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dd_sr        <= '0;
            dv_mag       <= '0;
            dividend_raw <= '0;
            rem          <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dv_zero      <= 1'b0;
            cnt          <= '0;
            o_done       <= 1'b0;
            o_q          <= '0;
            o_r          <= '0;
`ifdef SIGNED_DIV_ZERO_EN
            o_div_zero   <= 1'b0;
`endif
        end else begin
            o_done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        dd_sr        <= dd_mag_in;
                        dv_mag       <= dv_mag_in;
                        dividend_raw <= i_dividend;
                        q_neg        <= i_dividend[N-1] ^ i_divisor[N-1];
                        r_neg        <= i_dividend[N-1];
                        dv_zero      <= zero_in;
                        rem          <= '0;
                        cnt          <= CW'(N - 1);
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    dd_sr <= {dd_sr[N-2:0], q_bit};
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    o_q <= q_fix;
                    o_r <= r_fix;
`ifdef SIGNED_DIV_ZERO_EN
                    o_div_zero <= dv_zero;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench for signed_seq_divider (N=8): vector table, random ops,
// mid-operation start and reset corner cases.
module tb_signed_seq_divider;

    localparam int N = 8;
`ifdef SIGNED_DIV_ZERO_EN
    localparam bit ZE = 1'b1;
`else
    localparam bit ZE = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic         ready;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
`ifdef SIGNED_DIV_ZERO_EN
    logic         div_zero;
`endif

    signed_seq_divider #(.N(N)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_dividend (dd),
        .i_divisor  (dv),
        .o_ready    (ready),
        .o_done     (done),
        .o_q        (q),
        .o_r        (r)
`ifdef SIGNED_DIV_ZERO_EN
        ,
        .o_div_zero (div_zero)
`endif
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
        logic signed [N-1:0] q;
        logic signed [N-1:0] r;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest outstanding op.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got o_done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", q, e.q);
                chk("remainder", r, e.r);
                chk("latency", cyc - e.acc, e.lat);
`ifdef SIGNED_DIV_ZERO_EN
                chk("div_zero", div_zero, e.dz);
`endif
            end
        end
    end

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_start", ready, 1);
        start = 1'b1;
        dd    = a;
        dv    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dd    = N'($urandom);
        dv    = N'($urandom);
        e.q   = eq;
        e.r   = er;
        e.dz  = (b == '0);
        e.lat = (ZE && b == '0) ? 2 : N + 2;
        e.acc = cyc;
        sb.push_back(e);
        chk("ready_busy", ready, 0);
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done expected one within %0d cycles", t);
            sb.delete();
        end
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er);
        launch(a, b, eq, er);
        wait_empty();
    endtask

    vec_t vecs[12];

    initial begin
        int            d0;
        logic [N-1:0]  ra, rb, mq, mr;
        int            ai, bi;

        vecs[0]  = '{a:  100, b:    7, q:  14, r:    2};
        vecs[1]  = '{a: -100, b:    7, q: -14, r:   -2};
        vecs[2]  = '{a:  100, b:   -7, q: -14, r:    2};
        vecs[3]  = '{a: -100, b:   -7, q:  14, r:   -2};
        vecs[4]  = '{a: -128, b:   -1, q:-128, r:    0};
        vecs[5]  = '{a: -128, b:    1, q:-128, r:    0};
        vecs[6]  = '{a:  127, b:  127, q:   1, r:    0};
        vecs[7]  = '{a:    5, b:    0, q:  -1, r:    5};
        vecs[8]  = '{a:    0, b:    5, q:   0, r:    0};
        vecs[9]  = '{a:   -7, b: -128, q:   0, r:   -7};
        vecs[10] = '{a: -128, b:    0, q:  -1, r: -128};
        vecs[11] = '{a:    1, b:   -1, q:  -1, r:    0};

        rst_n = 1'b0;
        start = 1'b0;
        dd    = '0;
        dv    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_q", q, 0);
        chk("reset_r", r, 0);
`ifdef SIGNED_DIV_ZERO_EN
        chk("reset_div_zero", div_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = (i % 7 == 3) ? '0 : N'($urandom);
            ai = $signed(ra);
            bi = $signed(rb);
            if (bi == 0) begin
                mq = '1;
                mr = ra;
            end else begin
                mq = N'(ai / bi);
                mr = N'(ai % bi);
            end
            do_op(ra, rb, mq, mr);
        end

        // A start pulse during CALC must be ignored; result must then hold.
        d0 = done_cnt;
        launch(8'd100, 8'd7, 8'd14, 8'd2);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        dd    = 8'd9;
        dv    = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty();
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_start_done_count", done_cnt - d0, 1);
        chk("hold_q", q, 8'd14);
        chk("hold_r", r, 8'd2);

        // Reset in the 4th CALC cycle discards the op and clears outputs.
        @(negedge clk);
        start = 1'b1;
        dd    = 8'd100;
        dv    = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", ready, 1);
        chk("midreset_done", done, 0);
        chk("midreset_q", q, 0);
        chk("midreset_r", r, 0);
`ifdef SIGNED_DIV_ZERO_EN
        chk("midreset_div_zero", div_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        do_op(8'd9, 8'd2, 8'd4, 8'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("post_reset_done_count", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
